// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I 5-stage core.
// ctrl_t field order (MSB first) is the decode-to-execute control bundle layout.
package core_pkg;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       branch;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       valid;
   } ctrl_t;

   localparam logic [1:0] ALUOP_LDST = 2'b00;
   localparam logic [1:0] ALUOP_BR   = 2'b01;
   localparam logic [1:0] ALUOP_R    = 2'b10;
   localparam logic [1:0] ALUOP_I    = 2'b11;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detect: a valid load in EX whose destination
// matches either source index of the valid instruction in ID (x0 never matches).
module load_use_detect (
   input  logic       ex_mem_read,
   input  logic       ex_valid,
   input  logic [4:0] ex_rd,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_valid,
   output logic       luh
);

   assign luh = ex_mem_read & ex_valid & (ex_rd != 5'd0)
              & ((ex_rd == id_rs1) | (ex_rd == id_rs2)) & id_valid;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush, global hold,
// and saturating stall/flush event counters.
module id_ex_stage
   import core_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_rs1_data,
   input  logic [XLEN-1:0]  id_rs2_data,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic [2:0]       id_funct3,
   input  logic             id_funct7b5,
   input  ctrl_t            id_ctrl,
   input  logic             flush,
   input  logic             hold,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_rs1_data,
   output logic [XLEN-1:0]  ex_rs2_data,
   output logic [XLEN-1:0]  ex_imm,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic [2:0]       ex_funct3,
   output logic             ex_funct7b5,
   output ctrl_t            ex_ctrl,
   output logic             pc_write,
   output logic             if_id_write,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic luh;
   logic bubble;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   load_use_detect u_load_use_detect (
      .ex_mem_read (ex_ctrl.mem_read),
      .ex_valid    (ex_ctrl.valid),
      .ex_rd       (ex_rd),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_valid    (id_ctrl.valid),
      .luh         (luh)
   );

   // A flush squashes the dependent instruction, so it must not also stall fetch.
   assign bubble      = flush | luh;
   assign pc_write    = ~(hold | (luh & ~flush));
   assign if_id_write = pc_write;

   // ID -> EX boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_funct3   <= '0;
         ex_funct7b5 <= 1'b0;
         ex_ctrl     <= CTRL_BUBBLE;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else if (!hold) begin
         ex_pc       <= id_pc;
         ex_rs1_data <= id_rs1_data;
         ex_rs2_data <= id_rs2_data;
         ex_imm      <= id_imm;
         ex_rs1      <= id_rs1;
         ex_rs2      <= id_rs2;
         ex_rd       <= id_rd;
         ex_funct3   <= id_funct3;
         ex_funct7b5 <= id_funct7b5;
         ex_ctrl     <= bubble ? CTRL_BUBBLE : id_ctrl;
         if (flush)
            flush_cnt <= sat_inc(flush_cnt);
         else if (luh)
            stall_cnt <= sat_inc(stall_cnt);
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized plus directed bench for id_ex_stage against a cycle-level reference model.
module tb_id_ex_stage;
   import core_pkg::*;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
   localparam int SAT   = 15;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]       id_rs1, id_rs2, id_rd;
   logic [2:0]       id_funct3;
   logic             id_funct7b5;
   ctrl_t            id_ctrl;
   logic             flush, hold;
   logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]       ex_rs1, ex_rs2, ex_rd;
   logic [2:0]       ex_funct3;
   logic             ex_funct7b5;
   ctrl_t            ex_ctrl;
   logic             pc_write, if_id_write;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int checks = 0;
   int failures = 0;

   // reference model state
   ctrl_t       m_ctrl;
   logic [31:0] m_pc, m_a, m_b, m_imm;
   logic [4:0]  m_rs1, m_rs2, m_rd;
   logic [2:0]  m_f3;
   logic        m_f7;
   bit          m_known;
   int          m_stall, m_flush;

   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_funct3(id_funct3), .id_funct7b5(id_funct7b5), .id_ctrl(id_ctrl),
      .flush(flush), .hold(hold),
      .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_ctrl(ex_ctrl),
      .pc_write(pc_write), .if_id_write(if_id_write),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout obs=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=0x%0h exp=0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic ctrl_t mk(bit rw, bit mr, bit mw, bit m2r, bit br, bit src,
                                logic [1:0] op, bit v);
      ctrl_t c;
      c.reg_write = rw; c.mem_read = mr; c.mem_write = mw; c.mem_to_reg = m2r;
      c.branch = br; c.alu_src = src; c.alu_op = op; c.valid = v;
      return c;
   endfunction

   function automatic bit model_luh();
      return m_ctrl.mem_read && m_ctrl.valid && m_rd != 0 &&
             (m_rd == id_rs1 || m_rd == id_rs2) && id_ctrl.valid;
   endfunction

   task automatic model_reset();
      m_ctrl = '0; m_pc = 0; m_a = 0; m_b = 0; m_imm = 0;
      m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_f3 = 0; m_f7 = 0;
      m_known = 1; m_stall = 0; m_flush = 0;
   endtask

   task automatic model_edge();
      bit l;
      if (hold) return;
      l = model_luh();
      if (flush) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
      else if (l) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
      m_ctrl  = (flush || l) ? ctrl_t'(0) : id_ctrl;
      m_known = !(flush || l);
      m_pc = id_pc; m_a = id_rs1_data; m_b = id_rs2_data; m_imm = id_imm;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_f3 = id_funct3; m_f7 = id_funct7b5;
   endtask

   task automatic check_regs();
      chk("ex_ctrl", ex_ctrl, m_ctrl);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
      if (m_known) begin
         chk("ex_pc", ex_pc, m_pc);
         chk("ex_rs1_data", ex_rs1_data, m_a);
         chk("ex_rs2_data", ex_rs2_data, m_b);
         chk("ex_imm", ex_imm, m_imm);
         chk("ex_rs1", ex_rs1, m_rs1);
         chk("ex_rs2", ex_rs2, m_rs2);
         chk("ex_rd", ex_rd, m_rd);
         chk("ex_funct3", ex_funct3, m_f3);
         chk("ex_funct7b5", ex_funct7b5, m_f7);
      end
   endtask

   // called at a negedge with ID inputs already applied
   task automatic step();
      bit stall_exp;
      #1;
      stall_exp = hold || (model_luh() && !flush);
      chk("pc_write", pc_write, !stall_exp);
      chk("if_id_write", if_id_write, !stall_exp);
      @(posedge clk);
      model_edge();
      #1;
      check_regs();
      @(negedge clk);
   endtask

   task automatic rand_data();
      id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_funct3 = 3'($urandom); id_funct7b5 = 1'($urandom);
   endtask

   task automatic rand_all();
      rand_data();
      id_rs1 = 5'($urandom_range(0, 7));
      id_rs2 = 5'($urandom_range(0, 7));
      id_rd  = 5'($urandom_range(0, 7));
      id_ctrl = ctrl_t'($urandom);
      if ($urandom_range(0, 2) == 0) begin
         id_ctrl.mem_read = 1'b1;
         id_ctrl.valid = 1'b1;
      end
      hold  = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 7) == 0);
   endtask

   task automatic set_instr(ctrl_t c, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd);
      rand_data();
      id_ctrl = c; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
   endtask

   ctrl_t lw, add;

   initial begin
      lw  = mk(1, 1, 0, 1, 0, 1, ALUOP_LDST, 1);
      add = mk(1, 0, 0, 0, 0, 0, ALUOP_R, 1);
      rst_n = 1'b0; hold = 0; flush = 0;
      set_instr('0, 0, 0, 0);
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ex_ctrl", ex_ctrl, 0);
      chk("rst_ex_pc", ex_pc, 0);
      chk("rst_ex_rd", ex_rd, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_flush_cnt", flush_cnt, 0);
      chk("rst_pc_write", pc_write, 1);
      @(negedge clk);
      rst_n = 1'b1;

      // normal flow
      set_instr(add, 1, 2, 5);
      step();
      chk("norm_ex_rd", ex_rd, 5);
      chk("norm_rw", ex_ctrl.reg_write, 1);

      // load-use: LW x5 then ADD using x5
      set_instr(lw, 1, 0, 5);
      step();
      set_instr(add, 5, 6, 7);
      step();
      chk("lu_bubble", ex_ctrl, 0);
      chk("lu_stall_cnt", stall_cnt, 1);
      step();
      chk("lu_add_rd", ex_rd, 7);
      chk("lu_add_ctrl", ex_ctrl, add);

      // x0 guard
      set_instr(lw, 1, 0, 0);
      step();
      set_instr(add, 0, 0, 3);
      step();
      chk("x0_no_stall", stall_cnt, 1);

      // Valid guard
      set_instr(lw, 1, 0, 5);
      step();
      set_instr(mk(1, 0, 0, 0, 0, 0, ALUOP_R, 0), 5, 5, 4);
      step();
      chk("valid_no_stall", stall_cnt, 1);

      // flush overrides load-use
      set_instr(lw, 1, 0, 5);
      step();
      set_instr(add, 5, 0, 8);
      flush = 1;
      step();
      chk("fl_flush_cnt", flush_cnt, 1);
      chk("fl_stall_cnt", stall_cnt, 1);
      chk("fl_bubble", ex_ctrl, 0);
      flush = 0;

      // hold with flush pending
      set_instr(add, 1, 2, 9);
      step();
      hold = 1; flush = 1;
      for (int i = 0; i < 3; i++) begin
         set_instr(ctrl_t'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
         step();
         chk("hold_rd", ex_rd, 9);
      end
      hold = 0;
      step();
      chk("hold_rel_flush_cnt", flush_cnt, 2);
      chk("hold_rel_bubble", ex_ctrl, 0);
      flush = 0;

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         rand_all();
         step();
      end
      hold = 0; flush = 0;

      // asynchronous reset mid-cycle
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_ex_ctrl", ex_ctrl, 0);
      chk("arst_stall_cnt", stall_cnt, 0);
      chk("arst_flush_cnt", flush_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // flush counter saturation
      flush = 1;
      for (int i = 0; i < 20; i++) begin
         rand_data();
         step();
      end
      chk("sat_flush_cnt", flush_cnt, 15);
      flush = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
